calc_seq_alu: RTL and testbench

CALC_SEQ_ALU -- requirements
Module: calc_seq_alu

---
 rtl/calc_seq_alu.sv | 216 +++++++++++++++++++++
 tb/tb_calc_seq_alu.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_alu.sv
// Sequential calculator ALU: single-cycle ADD/SUB/AND/XOR, iterative shift-add MUL
// and restoring DIV, with registered operand/result copies for a display front end.
module calc_seq_alu #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned MODE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       op_sel,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [1:0]       Operation,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             dbz
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] OP_SUB = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [1:0]       op_q, op_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             ovf_q, ovf_d, dbz_q, dbz_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d, mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;

  logic [WIDTH:0]   add_full;
  logic [PW-1:0]    prod_nx;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  // One shift-add multiply step and one restoring-division step per CALC cycle
  always_comb begin
    add_full = {1'b0, op_a} + {1'b0, op_b};
    prod_nx  = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    div_ge   = (rem_sh >= {1'b0, b_q});
    rem_nx   = div_ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
    quo_nx   = {quo_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    op_d     = op_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = op_a;
          b_d   = op_b;
          op_d  = op_sel;
          ovf_d = 1'b0;
          dbz_d = 1'b0;
          cnt_d = '0;
          unique case (op_sel)
            OP_ADD: begin
              c_d     = add_full[WIDTH-1:0];
              ovf_d   = add_full[WIDTH];
              state_d = S_DONE;
              done_d  = 1'b1;
            end
            OP_SUB: begin
              c_d     = op_a - op_b;
              ovf_d   = (op_a < op_b);
              state_d = S_DONE;
              done_d  = 1'b1;
            end
            OP_MUL: begin
              if (MODE == 1) begin
                prod_d   = '0;
                mcand_d  = PW'(op_a);
                mplier_d = op_b;
                state_d  = S_CALC;
              end else begin
                c_d     = op_a & op_b;
                state_d = S_DONE;
                done_d  = 1'b1;
              end
            end
            default: begin
              if (MODE == 1) begin
                if (op_b == '0) begin
                  // Divide by zero bypasses the iteration entirely
                  c_d     = '1;
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
                  done_d  = 1'b1;
                end else begin
                  rem_d   = '0;
                  quo_d   = op_a;
                  state_d = S_CALC;
                end
              end else begin
                c_d     = op_a ^ op_b;
                state_d = S_DONE;
                done_d  = 1'b1;
              end
            end
          endcase
        end
      end

      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q == OP_MUL) begin
          prod_d   = prod_nx;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
        end
        // Only the final step is allowed to reach C
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (op_q == OP_MUL) begin
            c_d   = prod_nx[WIDTH-1:0];
            ovf_d = |prod_nx[PW-1:WIDTH];
          end else begin
            c_d = quo_nx;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      op_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign C         = c_q;
  assign Operation = op_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_calc_seq_alu.sv
// Scoreboard bench for calc_seq_alu (WIDTH=16, MODE=1): directed cases, busy/start
// interplay, reset mid-division and randomized operations against an arithmetic model.
module tb_calc_seq_alu;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [1:0]   op_sel = 2'b00;
  logic [W-1:0] A, B, C;
  logic [1:0]   Operation;
  logic         busy, done, ovf, dbz;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [1:0]   op;
    logic         ovf;
    logic         dbz;
    int           lat;
    int           s;
  } exp_t;

  exp_t sb_q[$];

  calc_seq_alu #(.WIDTH(W), .MODE(1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .A(A), .B(B), .C(C), .Operation(Operation),
    .busy(busy), .done(done), .ovf(ovf), .dbz(dbz)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from plain integer arithmetic
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] sel);
    exp_t e;
    longint unsigned ua, ub, r;
    ua = longint'(a);
    ub = longint'(b);
    e.a = a; e.b = b; e.op = sel; e.ovf = 1'b0; e.dbz = 1'b0; e.lat = 1; e.s = 0;
    e.c = '0;
    case (sel)
      2'b01: begin r = ua + ub; e.c = W'(r % 65536); e.ovf = (r >= 65536); end
      2'b00: begin r = ua + 65536 - ub; e.c = W'(r % 65536); e.ovf = (ua < ub); end
      2'b10: begin r = ua * ub; e.c = W'(r % 65536); e.ovf = (r >= 65536); e.lat = W + 1; end
      default: begin
        if (ub == 0) begin e.c = 16'hFFFF; e.dbz = 1'b1; end
        else begin e.c = W'(ua / ub); e.lat = W + 1; end
      end
    endcase
    return e;
  endfunction

  // Monitor: compares every done pulse against the oldest pending expectation
  logic [W-1:0] prev_c = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (done) begin
          check("pending_on_done", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("C", 32'(C), 32'(e.c));
            check("ovf", 32'(ovf), 32'(e.ovf));
            check("dbz", 32'(dbz), 32'(e.dbz));
            check("A", 32'(A), 32'(e.a));
            check("B", 32'(B), 32'(e.b));
            check("Operation", 32'(Operation), 32'(e.op));
            check("latency", 32'(cyc - e.s), 32'(e.lat));
          end
        end else begin
          check("c_hold", 32'(C), 32'(prev_c));
        end
      end
      prev_c = C;
    end
  end

  // Drive one request at a negedge in IDLE; returns #1 after the accepting edge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] sel);
    exp_t e;
    op_a = a; op_b = b; op_sel = sel; start = 1'b1;
    @(posedge clk);
    #1;
    e = model(a, b, sel);
    e.s = cyc - 1;
    sb_q.push_back(e);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    op_a = W'($urandom); op_b = W'($urandom); op_sel = 2'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  logic [W-1:0] da[7] = '{16'hFFFF, 16'd3, 16'd5, 16'd300, 16'd255, 16'd1000, 16'd9};
  logic [W-1:0] db[7] = '{16'h0002, 16'd5, 16'd3, 16'd300, 16'd255, 16'd7,    16'd0};
  logic [1:0]   ds[7] = '{2'b01,    2'b00, 2'b00, 2'b10,  2'b10,  2'b11,    2'b11};

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   rs;
    int n;
    exp_t e;

    repeat (3) @(negedge clk);
    check("rst_A", 32'(A), 32'd0);
    check("rst_B", 32'(B), 32'd0);
    check("rst_C", 32'(C), 32'd0);
    check("rst_flags", 32'({Operation, busy, done, ovf, dbz}), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      issue(da[i], db[i], ds[i]);
      wait_idle();
    end

    // Start pulse three cycles into a MUL must be ignored
    issue(16'd300, 16'd300, 2'b10);
    repeat (3) @(negedge clk);
    op_a = 16'd1234; op_b = 16'd77; op_sel = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Start held through DONE is only taken once back in IDLE
    issue(16'd7, 16'd9, 2'b10);
    @(negedge clk);
    op_a = 16'd5; op_b = 16'd6; op_sel = 2'b01; start = 1'b1;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("held_done_seen", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    check("held_idle_after_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    e = model(16'd5, 16'd6, 2'b01);
    e.s = cyc - 1;
    sb_q.push_back(e);
    start = 1'b0;
    wait_idle();

    // Reset mid-division: outputs clear at once, no completion follows
    issue(16'd1000, 16'd7, 2'b11);
    repeat (7) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_A", 32'(A), 32'd0);
    check("midrst_B", 32'(B), 32'd0);
    check("midrst_C", 32'(C), 32'd0);
    check("midrst_flags", 32'({Operation, busy, done, ovf, dbz}), 32'd0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    issue(16'd1, 16'd1, 2'b01);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      rs = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        default: rb = W'($urandom);
      endcase
      issue(ra, rb, rs);
      wait_idle();
    end

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
